// File: rtl/fp_acc_pkg.sv
// Shared types and helpers for the fixed-point dot-product accumulator.
package fp_acc_pkg;

  typedef enum logic {ACC, HOLD} state_e;

  // Signed clamp limits of a Q(ia.f) two's-complement value.
  function automatic longint sat_max(input int unsigned ia, input int unsigned f);
    return (longint'(1) << (ia + f - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned ia, input int unsigned f);
    return -(longint'(1) << (ia + f - 1));
  endfunction

  // Widens a w-bit value: sign-extend when sgn=1, zero-extend otherwise.
  function automatic longint extend(input logic [63:0] d, input int unsigned w, input logic sgn);
    logic [63:0] mask;
    mask = '1 << w;
    if (sgn && d[w-1]) return longint'(d | mask);
    else               return longint'(d & ~mask);
  endfunction

endpackage

// File: rtl/fp_sat_add.sv
// Combinational extend + add + clamp of one product into the accumulator.
module fp_sat_add
  import fp_acc_pkg::*;
#(
  parameter int unsigned I  = 2,
  parameter int unsigned F  = 14,
  parameter int unsigned IA = 6
) (
  input  logic [IA+F-1:0] acc,
  input  logic [I+F-1:0]  in_data,
  input  logic            in_signed,
  output logic [IA+F-1:0] sum,
  output logic            clamped
);

  localparam int unsigned AW = IA + F;
  localparam int unsigned SW = AW + 1;
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(IA, F));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(IA, F));

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] raw;

  always_comb begin
    ext     = SW'(extend(64'(in_data), I + F, in_signed));
    raw     = $signed({acc[AW-1], acc}) + ext;
    sum     = raw[AW-1:0];
    clamped = 1'b0;
    if (raw > MAXV) begin
      sum     = MAXV[AW-1:0];
      clamped = 1'b1;
    end else if (raw < MINV) begin
      sum     = MINV[AW-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/fp_dot_acc.sv
// Saturating dot-product accumulator: LEN (or in_last-terminated) products per result.
module fp_dot_acc
  import fp_acc_pkg::*;
#(
  parameter int unsigned I   = 2,
  parameter int unsigned F   = 14,
  parameter int unsigned IA  = 6,
  parameter int unsigned LEN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [I+F-1:0]  in_data,
  input  logic            in_signed,
  input  logic            in_ovf,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IA+F-1:0] out_data,
  output logic            out_sat,
  output logic            out_ovf
);

  localparam int unsigned AW = IA + F;
  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sat_q, sat_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   out_data_q, out_data_d;
  logic            out_sat_q, out_sat_d;
  logic            out_ovf_q, out_ovf_d;

  logic [AW-1:0]   sum;
  logic            clamped;

  fp_sat_add #(.I(I), .F(F), .IA(IA)) u_add (
    .acc       (acc_q),
    .in_data   (in_data),
    .in_signed (in_signed),
    .sum       (sum),
    .clamped   (clamped)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sum;
          sat_d = sat_q | clamped;
          ovf_d = ovf_q | in_ovf;
          cnt_d = cnt_q + CW'(1);
          if (in_last || cnt_q == CW'(LEN - 1)) begin
            state_d    = HOLD;
            out_data_d = sum;
            out_sat_d  = sat_q | clamped;
            out_ovf_d  = ovf_q | in_ovf;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_dot_acc.sv
// Directed bench for fp_dot_acc: three instances (LEN 8/4/16) share one input stream.
module tb_fp_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_signed, in_ovf, in_last, out_ready;
  logic [15:0] in_data;

  logic        rdy8, vld8, sat8, ovf8;
  logic [19:0] dat8;
  logic        rdy4, vld4, sat4, ovf4;
  logic [19:0] dat4;
  logic        rdy16, vld16, sat16, ovf16;
  logic [19:0] dat16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_dot_acc #(.I(2), .F(14), .IA(6), .LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
    .in_signed(in_signed), .in_ovf(in_ovf), .in_last(in_last), .out_valid(vld8),
    .out_ready(out_ready), .out_data(dat8), .out_sat(sat8), .out_ovf(ovf8));

  fp_dot_acc #(.I(2), .F(14), .IA(6), .LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_signed(in_signed), .in_ovf(in_ovf), .in_last(in_last), .out_valid(vld4),
    .out_ready(out_ready), .out_data(dat4), .out_sat(sat4), .out_ovf(ovf4));

  fp_dot_acc #(.I(2), .F(14), .IA(6), .LEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
    .in_signed(in_signed), .in_ovf(in_ovf), .in_last(in_last), .out_valid(vld16),
    .out_ready(out_ready), .out_data(dat16), .out_sat(sat16), .out_ovf(ovf16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n back-to-back beats; in_ovf on beat number ovf_at (1-based, 0 = none).
  task automatic beats(input int unsigned n, input logic [15:0] d, input logic sg,
                       input int unsigned ovf_at, input logic last_end);
    for (int unsigned k = 0; k < n; k++) begin
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = sg;
      in_ovf    = (k + 1 == ovf_at);
      in_last   = last_end && (k == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_ovf = 1'b0;
    in_last = 1'b0; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_out_valid", 32'(vld8), 32'h0);
    chk("rst_out_data",  32'(dat8), 32'h0);
    chk("rst_in_ready",  32'(rdy8), 32'h1);
    chk("rst_flags",     32'({sat8, ovf8}), 32'h0);

    // 1: 8 x 0.5 unsigned -> 4.0
    beats(7, 16'h2000, 1'b0, 0, 1'b0);
    chk("t1_no_early_valid", 32'(vld8), 32'h0);
    beats(1, 16'h2000, 1'b0, 0, 1'b0);
    chk("t1_valid", 32'(vld8), 32'h1);
    chk("t1_data",  32'(dat8), 32'h10000);
    chk("t1_flags", 32'({sat8, ovf8}), 32'h0);
    chk("t1_in_ready_hold", 32'(rdy8), 32'h0);
    tick();
    chk("t1_valid_one_cycle", 32'(vld8), 32'h0);
    chk("t1_in_ready_back", 32'(rdy8), 32'h1);

    // 2: LEN=4, signed then unsigned 0xC000
    do_reset();
    beats(4, 16'hC000, 1'b1, 0, 1'b0);
    chk("t2_valid_signed", 32'(vld4), 32'h1);
    chk("t2_data_signed",  32'(dat4), 32'hF0000);
    tick();
    beats(4, 16'hC000, 1'b0, 0, 1'b0);
    chk("t2_valid_unsigned", 32'(vld4), 32'h1);
    chk("t2_data_unsigned",  32'(dat4), 32'h30000);
    chk("t2_sat_unsigned",   32'(sat4), 32'h0);
    tick();

    // 3: LEN=16 saturation, then short in_last result
    do_reset();
    beats(16, 16'hFFFF, 1'b0, 0, 1'b0);
    chk("t3_valid_sat", 32'(vld16), 32'h1);
    chk("t3_data_sat",  32'(dat16), 32'h7FFFF);
    chk("t3_sat",       32'(sat16), 32'h1);
    tick();
    beats(2, 16'h1000, 1'b0, 0, 1'b1);
    chk("t3_valid_last", 32'(vld16), 32'h1);
    chk("t3_data_last",  32'(dat16), 32'h02000);
    chk("t3_sat_cleared", 32'(sat16), 32'h0);
    tick();

    // 4: back-pressure in HOLD
    do_reset();
    out_ready = 1'b0;
    beats(8, 16'h0800, 1'b0, 0, 1'b0);
    chk("t4_valid", 32'(vld8), 32'h1);
    chk("t4_data",  32'(dat8), 32'h04000);
    for (int unsigned c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      tick();
      chk("t4_hold_valid", 32'(vld8), 32'h1);
      chk("t4_hold_data",  32'(dat8), 32'h04000);
      chk("t4_hold_ready", 32'(rdy8), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_drain_valid", 32'(vld8), 32'h0);
    chk("t4_drain_ready", 32'(rdy8), 32'h1);

    // 5: in_ovf on beat 3 of one result only
    beats(8, 16'h0800, 1'b0, 3, 1'b0);
    chk("t5_valid", 32'(vld8), 32'h1);
    chk("t5_data",  32'(dat8), 32'h04000);
    chk("t5_ovf",   32'(ovf8), 32'h1);
    tick();
    beats(8, 16'h0800, 1'b0, 0, 1'b0);
    chk("t5_next_data", 32'(dat8), 32'h04000);
    chk("t5_next_ovf",  32'(ovf8), 32'h0);
    tick();

    // 6: reset mid-accumulation
    beats(5, 16'h2000, 1'b0, 0, 1'b0);
    do_reset();
    chk("t6_rst_valid", 32'(vld8), 32'h0);
    chk("t6_rst_data",  32'(dat8), 32'h0);
    tick(); tick(); tick();
    chk("t6_no_result", 32'(vld8), 32'h0);
    beats(7, 16'h0800, 1'b0, 0, 1'b0);
    chk("t6_no_early_valid", 32'(vld8), 32'h0);
    beats(1, 16'h0800, 1'b0, 0, 1'b0);
    chk("t6_valid", 32'(vld8), 32'h1);
    chk("t6_data",  32'(dat8), 32'h04000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_dot_acc.md
Name: fp_dot_acc

Overview:
- Downstream consumer of the fixed-point multiplier stage.
- Accumulates a stream of Q(I.F) products, signed or unsigned per beat, into a wider Q(IA.F) signed accumulator with saturation.
- Emits one dot-product result per LEN terms, or earlier on in_last.
- Valid/ready on both sides, so the combinational multiplier can be registered-fed and the result back-pressured.

Parameters:
- I, 2, integer bits of each incoming product (matches multiplier i3).
- F, 14, fractional bits of product and accumulator (matches multiplier f3).
- IA, 6, integer bits of accumulator/result, signed two's complement; IA > I required.
- LEN, 8, terms per result; LEN >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  accumulator can take a beat.
- in_data  in  I+F  product value (multiplier c).
- in_signed  in  1  1: in_data is two's complement; 0: unsigned (multiplier sign).
- in_ovf  in  1  upstream overflow/underflow flag for this beat.
- in_last  in  1  terminate the current result after this beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  IA+F  signed Q(IA.F) result.
- out_sat  out  1  accumulator saturated at least once during this result.
- out_ovf  out  1  at least one accepted beat had in_ovf=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACC, acc=0, cnt=0, sat/ovf stickies=0.
  - out_valid=0, out_data=0, out_sat=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-accumulation or mid-HOLD discards everything; no result is emitted.
- States: ACC, HOLD.
  - in_ready = (state==ACC), registered-state decode, no combinational path from out_ready.
- ACC, beat accepted (in_valid & in_ready):
  - Extend in_data to IA+F+1 bits: sign-extend if in_signed=1, else zero-extend.
  - Add to acc sign-extended by 1 bit.
  - Clamp to [-2^(IA+F-1), 2^(IA+F-1)-1]. If clamped, sat sticky is set.
  - ovf sticky |= in_ovf. cnt increments.
- Result close: accepted beat with cnt==LEN-1 or in_last=1.
  - Next cycle: state=HOLD, out_valid=1, out_data = clamped sum including that beat, out_sat/out_ovf = stickies including that beat.
  - Latency is 1 clk from the final accepted beat to out_valid.
- HOLD:
  - out_data/out_sat/out_ovf held stable while out_valid=1 and out_ready=0.
  - in_valid is ignored.
- out_valid & out_ready in HOLD:
  - Next cycle: out_valid=0; acc, cnt and stickies cleared; state=ACC; in_ready=1.
  - out_data keeps its last value (don't-care when out_valid=0).
- Throughput: LEN+1 cycles per result minimum; no overlap of result drain with the next accumulation.
- Once saturated, later beats add to the clamped value, so a negative beat can bring the accumulator back in range; out_sat stays 1 for that result.
- cnt width: $clog2(LEN) with a minimum of 1.
- LEN=1: every accepted beat produces a result.
- in_last on beat cnt==LEN-1 has the same effect as without it.
- in_valid with no in_ready: the beat is not consumed; upstream must hold it.

Decomposition:
- Package fp_acc_pkg:
  - state enum {ACC, HOLD}.
  - Function computing the clamp limits from IA and F.
  - Function for the width-extension rule.
- One sub-module, fp_sat_add: combinational extend + add + clamp.
  - Inputs: acc, in_data, in_signed.
  - Outputs: sum, clamped flag.
- fp_dot_acc owns the FSM, counter, stickies and output registers.

Test Plan:
1. Default params, 8 unsigned beats of 0x2000 (0.5), out_ready=1 -> out_data=0x10000 (4.0), out_sat=0, out_ovf=0; out_valid 1 clk after the 8th beat, high for exactly 1 cycle.
2. LEN=4, 4 signed beats of 0xC000 (-1.0) -> out_data=0xF0000 (-4.0); then 4 unsigned beats of 0xC000 (3.0) -> out_data=0x30000 (12.0), proving per-beat extension.
3. LEN=16, 16 unsigned beats of 0xFFFF -> out_data=0x7FFFF, out_sat=1; next result of 2 beats 0x1000 with in_last on the 2nd -> out_data=0x02000, out_sat=0.
4. Result pending, out_ready=0 for 5 cycles while in_valid=1 -> out_valid and out_data stable, in_ready=0, no beats consumed; out_ready=1 -> in_ready=1 next cycle.
5. in_ovf=1 on the 3rd of 8 beats -> out_ovf=1 for that result only; following result out_ovf=0.
6. rst_n=0 for 1 cycle after 5 of 8 beats -> out_valid never asserts for that result; next 8 beats of 0x0800 -> out_data=0x04000, counted from zero.
